// File: rtl/pingpong_tx_scheduler.sv
`default_nettype none
// ============================================================================
// pingpong_tx_scheduler: ping-pong SPRAM bank control and UART readout sequencer
// Rev 1.0
// ============================================================================
module pingpong_tx_scheduler #(
    parameter int         ADDR_W        = 14,
    parameter int         SENSOR_LEN    = 384,
    parameter int         EOP_PER_FRAME = 8,
    parameter logic [7:0] START_CMD     = 8'hAB,
    parameter logic [7:0] STOP_CMD      = 8'hCD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_data,
    input  logic              sens_eop,
    input  logic              sens_wr,
    input  logic              vec_wr,
    output logic [ADDR_W-1:0] sens_addr0,
    output logic [ADDR_W-1:0] sens_addr1,
    output logic              sens_we0,
    output logic              sens_we1,
    output logic [ADDR_W-1:0] vec_addr0,
    output logic [ADDR_W-1:0] vec_addr1,
    output logic              vec_we0,
    output logic              vec_we1,
    input  logic [7:0]        sens_rdata0,
    input  logic [7:0]        sens_rdata1,
    input  logic [7:0]        vec_rdata0,
    input  logic [7:0]        vec_rdata1,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              bank_sel,
    output logic              enabled,
    output logic              overrun
);

    localparam int                EOP_W       = (EOP_PER_FRAME > 1) ? $clog2(EOP_PER_FRAME) : 1;
    localparam logic [ADDR_W-1:0] C_ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] C_SENS_LAST = ADDR_W'(SENSOR_LEN - 1);
    localparam logic [EOP_W-1:0]  C_EOP_LAST  = EOP_W'(EOP_PER_FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              sec_q, sec_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              bank_sel_q, bank_sel_d;
    logic              enabled_q, enabled_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] sens_cnt_q, sens_cnt_d;
    logic [ADDR_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [EOP_W-1:0]  eop_cnt_q, eop_cnt_d;
    logic [ADDR_W-1:0] vec_len_q, vec_len_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic              w_swap;
    logic              w_sens_acc;
    logic              w_vec_acc;
    logic [7:0]        w_rd_byte;

    assign w_swap     = sens_eop && (eop_cnt_q == C_EOP_LAST);
    assign w_sens_acc = sens_wr && (sens_cnt_q != C_ADDR_MAX);
    assign w_vec_acc  = vec_wr && (vec_cnt_q != C_ADDR_MAX);
    assign w_rd_byte  = sec_q ? (bank_sel_q ? vec_rdata0 : vec_rdata1)
                              : (bank_sel_q ? sens_rdata0 : sens_rdata1);

    // bank_sel=0: bank 0 is the write bank, bank 1 is the read bank
    assign sens_we0   = rst_n && !bank_sel_q && w_sens_acc;
    assign sens_we1   = rst_n &&  bank_sel_q && w_sens_acc;
    assign vec_we0    = rst_n && !bank_sel_q && w_vec_acc;
    assign vec_we1    = rst_n &&  bank_sel_q && w_vec_acc;
    assign sens_addr0 = bank_sel_q ? rd_addr_q : sens_cnt_q;
    assign sens_addr1 = bank_sel_q ? sens_cnt_q : rd_addr_q;
    assign vec_addr0  = bank_sel_q ? rd_addr_q : vec_cnt_q;
    assign vec_addr1  = bank_sel_q ? vec_cnt_q : rd_addr_q;

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign bank_sel   = bank_sel_q;
    assign enabled    = enabled_q;
    assign overrun    = overrun_q;

    always_comb begin
        enabled_d  = enabled_q;
        overrun_d  = overrun_q;
        bank_sel_d = bank_sel_q;
        vec_len_d  = vec_len_q;
        sens_cnt_d = sens_cnt_q + ADDR_W'(w_sens_acc);
        vec_cnt_d  = vec_cnt_q + ADDR_W'(w_vec_acc);
        eop_cnt_d  = eop_cnt_q + EOP_W'(sens_eop);
        state_d    = state_q;
        sec_d      = sec_q;
        rd_addr_d  = rd_addr_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;

        if (cmd_valid && (cmd_data == START_CMD)) begin
            enabled_d = 1'b1;
            overrun_d = 1'b0;
        end else if (cmd_valid && (cmd_data == STOP_CMD)) begin
            enabled_d = 1'b0;
        end

        if (w_swap) begin
            bank_sel_d = ~bank_sel_q;
            vec_len_d  = vec_cnt_d;
            sens_cnt_d = '0;
            vec_cnt_d  = '0;
            eop_cnt_d  = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_swap && enabled_d) begin
                    state_d   = S_ADDR;
                    sec_d     = 1'b0;
                    rd_addr_d = '0;
                end
            end
            // A byte abandoned by a swap may still be on the wire; let it finish.
            S_ADDR: begin
                if (!tx_busy) state_d = S_LATCH;
            end
            S_LATCH: begin
                tx_data_d  = w_rd_byte;
                tx_start_d = 1'b1;
                state_d    = S_START;
            end
            S_START: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (!enabled_q) begin
                        state_d = S_IDLE;
                    end else if (!sec_q) begin
                        if (rd_addr_q == C_SENS_LAST) begin
                            sec_d     = 1'b1;
                            rd_addr_d = '0;
                            state_d   = (vec_len_q == '0) ? S_IDLE : S_ADDR;
                        end else begin
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
                            state_d   = S_ADDR;
                        end
                    end else begin
                        if (rd_addr_q == vec_len_q - ADDR_W'(1)) begin
                            state_d = S_IDLE;
                        end else begin
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
                            state_d   = S_ADDR;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_swap && (state_q != S_IDLE)) begin
            overrun_d  = 1'b1;
            tx_start_d = 1'b0;
            sec_d      = 1'b0;
            rd_addr_d  = '0;
            state_d    = enabled_d ? S_ADDR : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sec_q      <= 1'b0;
            rd_addr_q  <= '0;
            bank_sel_q <= 1'b0;
            enabled_q  <= 1'b0;
            overrun_q  <= 1'b0;
            sens_cnt_q <= '0;
            vec_cnt_q  <= '0;
            eop_cnt_q  <= '0;
            vec_len_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            rd_addr_q  <= rd_addr_d;
            bank_sel_q <= bank_sel_d;
            enabled_q  <= enabled_d;
            overrun_q  <= overrun_d;
            sens_cnt_q <= sens_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            eop_cnt_q  <= eop_cnt_d;
            vec_len_q  <= vec_len_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule
`default_nettype wire
